// File: rtl/data_mem_unit_pkg.sv
// data_mem_unit_pkg: size codes and FSM states shared by the data memory unit.
package data_mem_unit_pkg;
  typedef enum logic [1:0] {NONE = 2'b00, BYTE = 2'b01, HALFWORD = 2'b10, WORD = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/data_ram_be.sv
// data_ram_be: word array with byte-enable synchronous write and combinational read.
module data_ram_be #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [2**AW];
  always_ff @(posedge clk_i)
    for (int b = 0; b < 4; b++)
      if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage data memory with lane steering, load extension,
// misalignment exceptions and a fixed-latency stall/done handshake.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        req_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic [1:0]  ctrl_mem_read_i,
  input  logic [1:0]  ctrl_mem_write_i,
  input  logic        ctrl_unsigned_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misaligned_o
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
    return (sz == HALFWORD && a[0]) || (sz == WORD && a != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lane);
    return sz == BYTE ? 4'b0001 << lane : sz == HALFWORD ? (lane[1] ? 4'b1100 : 4'b0011) :
           sz == WORD ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input size_e sz,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    return sz == BYTE ? {{24{~uns & b[7]}}, b} : sz == HALFWORD ? {{16{~uns & h[15]}}, h} : w;
  endfunction

  size_e                 wr_sz, rd_sz, sz, sz_q;
  state_e                state_q;
  logic                  access, fire, wr_q, uns_q, done_q, mis_q, unused_addr;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q, ram_rdata, ram_wdata;

  assign wr_sz  = size_e'(ctrl_mem_write_i);
  assign rd_sz  = size_e'(ctrl_mem_read_i);
  // A store takes priority when both size codes are set.
  assign sz     = wr_sz != NONE ? wr_sz : rd_sz;
  assign access = req_i && (wr_sz != NONE || rd_sz != NONE);
  assign fire   = state_q == BUSY && cnt_q == '0;
  assign unused_addr = ^address_i[31:ADDR_WIDTH];
  assign ram_wdata = sz_q == BYTE ? {4{wdata_q[7:0]}} : sz_q == HALFWORD ? {2{wdata_q[15:0]}} : wdata_q;

  data_ram_be #(.AW(ADDR_WIDTH - 2)) u_ram (
    .clk_i   (clk_i),
    .we_i    (fire && wr_q),
    .be_i    (byte_en(sz_q, addr_q[1:0])),
    .addr_i  (addr_q[ADDR_WIDTH-1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sz_q    <= NONE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          mis_q  <= 1'b0;
          if (access && is_misaligned(sz, address_i[1:0])) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            mis_q   <= 1'b1;
          end else if (access) begin
            state_q <= BUSY;
            cnt_q   <= CW'(LATENCY - 1);
            addr_q  <= address_i[ADDR_WIDTH-1:0];
            wdata_q <= write_data_i;
            sz_q    <= sz;
            wr_q    <= wr_sz != NONE;
            uns_q   <= ctrl_unsigned_i;
          end
        end
        BUSY: begin
          if (!fire) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (!wr_q) rdata_q <= load_ext(ram_rdata, sz_q, addr_q[1:0], uns_q);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o      = (state_q == IDLE && access) || state_q == BUSY;
  assign read_data_o  = rdata_q;
  assign done_o       = done_q;
  assign misaligned_o = mis_q;
endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Parametrised data memory for the MEM stage. It supports byte-addressed, little-endian word, halfword and byte accesses on the correct byte lanes, and signed or unsigned loads. Misaligned accesses are detected and raise an exception instead of touching memory. Access latency is configurable, and a stall/done handshake holds the EX/MEM register while an access is in flight.

Parameters:
- ADDR_WIDTH, 10: byte-address bits decoded. Storage is 2**(ADDR_WIDTH-2) 32-bit words. Minimum value 3.
- LATENCY, 2: cycles spent in BUSY per access. Minimum value 1.

Ports:
- clk_i  in  1  clock, rising-edge
- n_rst_i  in  1  asynchronous active-low reset
- req_i  in  1  access request from EX/MEM; held stable while stall_o is high
- address_i  in  32  byte address; only [ADDR_WIDTH-1:0] is used
- write_data_i  in  32  store data, right-justified
- ctrl_mem_read_i  in  2  load size code (NONE/BYTE/HALFWORD/WORD)
- ctrl_mem_write_i  in  2  store size code
- ctrl_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
- read_data_o  out  32  extended load result, registered
- stall_o  out  1  pipeline hold request, combinational
- done_o  out  1  one-cycle completion pulse, registered
- misaligned_o  out  1  alignment exception, valid while done_o is high

Behaviour:
- Reset: clk_i is a single clock; n_rst_i is asynchronous, active-low.
  - On reset: state=IDLE, read_data_o=0, done_o=0, misaligned_o=0, counter=0.
  - The storage array is never reset.
  - Reset during BUSY discards the pending access; the array is not modified.
- Access definition: access = req_i & (ctrl_mem_write_i!=NONE | ctrl_mem_read_i!=NONE).
  - If both write and read are non-NONE, the write wins and the read is ignored.
- Alignment:
  - HALFWORD is misaligned if addr[0]=1.
  - WORD is misaligned if addr[1:0]!=0.
  - BYTE is always aligned.
- Addressing:
  - word index = addr[ADDR_WIDTH-1:2]; upper address bits are ignored, so addresses alias.
  - byte lane = addr[1:0]; halfword lane = addr[1].
- Write: byte-enable update of the selected lanes only, taking data from write_data_i[7:0] or [15:0]. Other lanes are preserved.
- Read: the selected lane is extended to 32 bits per ctrl_unsigned_i.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, access, aligned: latch address/data/controls, load counter=LATENCY-1, go to BUSY.
  - IDLE, access, misaligned: go to DONE with misaligned_o=1; no array access; read_data_o unchanged.
  - BUSY, counter!=0: decrement counter.
  - BUSY, counter==0: perform the access at this edge (write updates the array; read loads read_data_o), then go to DONE.
  - DONE: done_o=1 for exactly this cycle, then go to IDLE. req_i is ignored in DONE, so the held request is not re-accepted.
- stall_o = (IDLE & access) | BUSY.
  - For an aligned access, stall_o is high for LATENCY+1 cycles; done_o follows in the next cycle.
  - For a misaligned access, stall_o is high for 1 cycle.
- read_data_o holds its value until the next completed aligned read. Writes do not change it.
- A read issued right after a write to the same word returns the new data, because the write is committed before DONE.
- done_o and misaligned_o are low in every state other than DONE.

Decomposition:
- Shared header constants:
  - Size codes: NONE=2'b00, BYTE=2'b01, HALFWORD=2'b10, WORD=2'b11.
  - FSM state encodings: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module, data_ram_be: the synchronous word array with a 4-bit byte-enable write and a combinational read.
- Lane alignment and extension stay in data_mem_unit as functions.

Test Plan:
1. Reset: hold n_rst_i=0 with req_i=1 -> read_data_o=0, done_o=0, misaligned_o=0, stall_o low after release until a request is presented.
2. Word write 0xDEADBEEF to 0x10, then a word read of 0x10 with LATENCY=2 -> read_data_o=0xDEADBEEF; stall_o high 3 cycles and done_o pulses in cycle 4 for each access.
3. Byte write 0x80 to 0x13, then reads:
   - signed byte 0x13 -> 0xFFFFFF80
   - unsigned byte 0x13 -> 0x00000080
   - word 0x10 -> 0x80ADBEEF
   - signed halfword 0x12 -> 0xFFFF80AD
4. Word read at 0x11 -> misaligned_o=1 with done_o, stall_o high 1 cycle, read_data_o unchanged, and a later word read of 0x10 is unchanged.
5. Word write 0x12345678 to 0x20, with n_rst_i pulsed low during BUSY -> outputs return to 0 and a word read of 0x20 returns the previous contents.
6. With ADDR_WIDTH=10: word read of 0x410 -> same data as 0x10. Write and read in the same request -> the write is committed and read_data_o is unchanged. LATENCY=1 -> stall_o high 2 cycles.
